// File: rtl/mux_n_rr.sv
// mux_n_rr: N-channel registered mux with valid/ready handshakes, fixed-select
// or round-robin arbitration, and out-of-range select flagging.

// Per-channel ready: a channel is acknowledged only when it holds the grant
// and the output register can take a beat.
module mux_n_rr_lane #(
  parameter int SELW = 2,
  parameter int IDX  = 0
) (
  input  logic            rst_n,
  input  logic            load_ok,
  input  logic [SELW-1:0] gnt,
  output logic            ready
);
  assign ready = rst_n && load_ok && (gnt == SELW'(IDX));
endmodule

module mux_n_rr #(
  parameter int WIDTH = 32,
  parameter int N     = 3,
  parameter int SELW  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_chan,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               err_sel
);
  localparam int              NP  = 1 << SELW;
  localparam logic [SELW:0]   N_L = (SELW+1)'(N);

  logic [N-1:0][WIDTH-1:0] din;
  logic [NP-1:0]           vld_pad;
  logic                    sel_ok;
  logic                    load_en;
  logic                    gnt_vld;
  logic                    xfer;
  logic [SELW-1:0]         gnt;
  logic [WIDTH-1:0]        gnt_data;
  int                      idx;

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_chan_q, out_chan_d;
  logic             out_valid_q, out_valid_d;
  logic             err_sel_q, err_sel_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  assign din     = in_data;
  assign sel_ok  = ({1'b0, sel} < N_L);
  assign load_en = !out_valid_q || out_ready;
  assign xfer    = gnt_vld && load_en;

  // Grant: fixed select in mode 0 (out-of-range select grants nothing),
  // otherwise the first valid channel scanning upward from ptr with wrap.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    vld_pad = '0;
    vld_pad[N-1:0] = in_valid;
    if (!mode) begin
      gnt     = sel;
      gnt_vld = sel_ok && vld_pad[sel];
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= N) idx = idx - N;
        if (!gnt_vld && in_valid[idx]) begin
          gnt_vld = 1'b1;
          gnt     = idx[SELW-1:0];
        end
      end
    end
  end

  // Data of the granted channel; a decoded loop keeps indexing in range.
  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N; i++)
      if (gnt == SELW'(i)) gnt_data = din[i];
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    mux_n_rr_lane #(.SELW(SELW), .IDX(i)) u_lane (
      .rst_n   (rst_n),
      .load_ok (xfer),
      .gnt     (gnt),
      .ready   (in_ready[i])
    );
  end

  // Output stage next state: load on transfer (replacing any drained beat),
  // clear valid on drain, hold otherwise; rr pointer moves on mode-1 transfers.
  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    err_sel_d   = !mode && !sel_ok;
    if (xfer) begin
      out_data_d  = gnt_data;
      out_chan_d  = gnt;
      out_valid_d = 1'b1;
      if (mode) ptr_d = (gnt == SELW'(N-1)) ? '0 : gnt + SELW'(1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset discards any held beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      err_sel_q   <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      err_sel_q   <= err_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;
  assign err_sel   = err_sel_q;
endmodule

// File: doc/mux_n_rr.md
Name: mux_n_rr

Overview:
- Parametrised N-channel, WIDTH-bit registered multiplexer with valid/ready handshakes on every input and on the output.
- Successor to the combinational 3:1 32-bit mux. Adds a registered output stage, per-channel backpressure, a round-robin arbitration mode and out-of-range select detection.
- Sits between producer channels (ALU/load paths) and a single downstream consumer.

Parameters:
- WIDTH, 32, data width per channel in bits.
- N, 3, number of input channels (2..16).
- SELW, 2, select/channel-index width; must satisfy 2**SELW >= N.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous reset, active low.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; combinational.
- mode  input  1  0 = fixed select via sel; 1 = round-robin.
- sel  input  SELW  channel index used in mode 0.
- out_data  output  WIDTH  registered output word.
- out_chan  output  SELW  registered index of the channel that produced out_data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream ready.
- err_sel  output  1  registered; high for the cycle after mode 0 with sel >= N.

Behaviour:
- Reset (async, rst_n=0): out_data=0, out_chan=0, out_valid=0, err_sel=0, rr pointer ptr=0. in_ready=0 while in reset. Outputs drop immediately, not at the next edge.
- Reset mid-operation: any beat held in the output register is discarded. No channel is acknowledged during reset.
- load_en = !out_valid || out_ready.
- Grant (combinational, one channel at most):
  - mode 0, sel < N: grant = sel if in_valid[sel].
  - mode 0, sel >= N: no grant; all in_ready=0. The out-of-range select never passes data, unlike the old mux, which drove 0.
  - mode 1: grant = first i with in_valid[i]=1, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wrap-around).
- in_ready[i] = load_en && granted && (grant == i). Transfer on channel i occurs when in_valid[i] && in_ready[i] at the rising edge.
- On transfer: out_data <= channel data, out_chan <= grant, out_valid <= 1. Latency 1 cycle from input transfer to out_valid.
- On out_valid && out_ready with no new transfer: out_valid <= 0. out_data and out_chan hold their last values.
- Simultaneous output drain and input transfer in one cycle: the new beat replaces the old one with no bubble. Throughput is 1 beat/cycle while out_ready=1.
- out_valid=1 && out_ready=0: out_data, out_chan and out_valid are held stable; all in_ready=0.
- ptr updates only on a mode-1 transfer: ptr <= (grant == N-1) ? 0 : grant+1. A mode-0 transfer leaves ptr unchanged.
- Mode or sel change takes effect combinationally for the next grant. A beat already in the output register is unaffected.
- err_sel <= (mode == 0 && sel >= N) every cycle, regardless of in_valid. With N = 2**SELW, err_sel is constantly 0.
- No data is ever duplicated or dropped. Every accepted beat appears exactly once on the output.

Test Plan:
- Reset: assert rst_n=0 mid-stream with out_valid=1 -> out_valid, out_data, out_chan and err_sel read 0 within the same cycle; in_ready=0; after release, the first grant in mode 1 goes to channel 0.
- Fixed select, N=3, WIDTH=32, channel data a=AAAAAAAA, b=55555555, c=DEADBEEF, all valid, out_ready=1, mode 0: sel=00/01/10 -> one cycle later out_data=AAAAAAAA/55555555/DEADBEEF with out_chan=0/1/2.
- Out of range: mode 0, sel=11, all valid -> in_ready=000 and no out_valid; err_sel=1 from the next cycle; sel=00 -> err_sel=0 next cycle and data a flows.
- Round-robin fairness: mode 1, all three valid for 6 cycles, out_ready=1 -> out_chan sequence 0,1,2,0,1,2 with out_valid continuously 1. With only channels 0 and 2 valid -> 0,2,0,2.
- Backpressure: out_ready=0 for 4 cycles with out_valid=1 -> out_data stable, in_ready=000. Raising out_ready -> drain and new accept in the same cycle with no bubble.
- Wrap and skip: mode 1, ptr=2, only channel 1 valid -> grant 1, after which ptr becomes 2.
